// File: rtl/alu_pkg.sv
// alu_pkg: function codes, FSM state type and opcode helper shared by the iterative ALU
package alu_pkg;
    localparam logic [5:0] ALU_AND = 6'b100100;
    localparam logic [5:0] ALU_OR  = 6'b100101;
    localparam logic [5:0] ALU_ADD = 6'b100000;
    localparam logic [5:0] ALU_SUB = 6'b100010;
    localparam logic [5:0] ALU_SLT = 6'b101010;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    // SUB and SLT both compute A + ~B + 1
    function automatic logic is_sub(input logic [5:0] op);
        return op == ALU_SUB || op == ALU_SLT;
    endfunction
endpackage

// File: rtl/alu_iter_if.sv
// alu_iter_if: request/response handshake bundle of alu_iter
// master drives in_valid/Signal/dataA/dataB/out_ready; slave (the ALU) drives
// in_ready/out_valid/dataOut/c_out/zero and, with ALU_OVERFLOW_EN, overflow.
interface alu_iter_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       Signal;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dataOut;
    logic             c_out;
    logic             zero;
`ifdef ALU_OVERFLOW_EN
    logic             overflow;
`endif
    modport master (
        output in_valid, Signal, dataA, dataB, out_ready,
`ifdef ALU_OVERFLOW_EN
        input  overflow,
`endif
        input  in_ready, out_valid, dataOut, c_out, zero
    );
    modport slave (
        input  in_valid, Signal, dataA, dataB, out_ready,
`ifdef ALU_OVERFLOW_EN
        output overflow,
`endif
        output in_ready, out_valid, dataOut, c_out, zero
    );
endinterface

// File: rtl/alu_slice.sv
// alu_slice: combinational SLICE-bit ripple-carry chunk of the iterative ALU
// i_a/i_b operand bits, i_invert complements B, i_cin chunk carry-in, i_op function code;
// o_y chunk result, o_cout carry-out, o_cmsb carry into the top bit (overflow detection).
module alu_slice
    import alu_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic             i_invert,
    input  logic             i_cin,
    input  logic [5:0]       i_op,
    output logic [SLICE-1:0] o_y,
    output logic             o_cout,
    output logic             o_cmsb
);
    logic [SLICE-1:0] w_bb;
    logic [SLICE-1:0] w_s;
    logic [SLICE:0]   w_c;
    assign w_bb   = i_b ^ {SLICE{i_invert}};
    assign w_c[0] = i_cin;
    for (genvar g = 0; g < SLICE; g++) begin : g_fa
        assign w_s[g]   = i_a[g] ^ w_bb[g] ^ w_c[g];
        assign w_c[g+1] = (i_a[g] & w_bb[g]) | (w_c[g] & (i_a[g] ^ w_bb[g]));
    end
    assign o_y = i_op == ALU_AND ? i_a & i_b :
                 i_op == ALU_OR  ? i_a | i_b :
                 (i_op == ALU_ADD || is_sub(i_op)) ? w_s : '0;
    assign o_cout = w_c[SLICE];
    assign o_cmsb = w_c[SLICE-1];
endmodule

// File: rtl/alu_iter.sv
// alu_iter: multi-cycle AND/OR/ADD/SUB/SLT ALU processing SLICE bits per clock
// clk, reset (async active-low); bus = alu_iter_if.slave handshake (request in, result out).
// Optional macro ALU_OVERFLOW_EN adds the registered signed-overflow output.
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic     clk,
    input  logic     reset,
    alu_iter_if.slave bus
);
    localparam int N  = WIDTH / SLICE;
    localparam int KW = N > 1 ? $clog2(N) : 1;
    if (WIDTH % SLICE != 0) begin : g_bad_cfg
        $error("alu_iter: WIDTH must be a multiple of SLICE");
    end
    state_t           r_state;
    logic [5:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic [KW-1:0]    r_k;
    logic             r_c_out;
    logic             r_zero;
`ifdef ALU_OVERFLOW_EN
    logic             r_ovf;
`endif
    logic [SLICE-1:0] w_y;
    logic             w_cout;
    logic             w_cmsb;
    logic             w_last;
    logic             w_v;
    logic             w_arith;
    logic [WIDTH-1:0] w_merged;
    logic [WIDTH-1:0] w_final;
    alu_slice #(.SLICE(SLICE)) u_slice (
        .i_a      (r_a[r_k*SLICE +: SLICE]),
        .i_b      (r_b[r_k*SLICE +: SLICE]),
        .i_invert (is_sub(r_op)),
        .i_cin    (r_carry),
        .i_op     (r_op),
        .o_y      (w_y),
        .o_cout   (w_cout),
        .o_cmsb   (w_cmsb)
    );
    assign w_last  = r_k == KW'(N - 1);
    assign w_v     = w_cout ^ w_cmsb;
    assign w_arith = r_op == ALU_ADD || r_op == ALU_SUB;
    always_comb begin
        w_merged = r_result;
        w_merged[r_k*SLICE +: SLICE] = w_y;
    end
    // SLT: sign of the difference corrected by signed overflow
    assign w_final = (w_last && r_op == ALU_SLT) ? WIDTH'(w_y[SLICE-1] ^ w_v) : w_merged;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_k      <= '0;
            r_c_out  <= 1'b0;
            r_zero   <= 1'b0;
`ifdef ALU_OVERFLOW_EN
            r_ovf    <= 1'b0;
`endif
        end else if (r_state == IDLE) begin
            if (bus.in_valid) begin
                r_op     <= bus.Signal;
                r_a      <= bus.dataA;
                r_b      <= bus.dataB;
                r_result <= '0;
                r_carry  <= is_sub(bus.Signal);
                r_k      <= '0;
                r_c_out  <= 1'b0;
                r_zero   <= 1'b0;
`ifdef ALU_OVERFLOW_EN
                r_ovf    <= 1'b0;
`endif
                r_state  <= RUN;
            end
        end else if (r_state == RUN) begin
            r_result <= w_final;
            r_carry  <= w_cout;
            r_k      <= r_k + 1'b1;
            if (w_last) begin
                r_c_out <= w_arith & w_cout;
                r_zero  <= w_final == '0;
`ifdef ALU_OVERFLOW_EN
                r_ovf   <= w_arith & w_v;
`endif
                r_state <= DONE;
            end
        end else if (bus.out_ready) begin
            r_state <= IDLE;
        end
    end
    // in_ready is forced low while reset is held
    assign bus.in_ready  = reset && r_state == IDLE;
    assign bus.out_valid = r_state == DONE;
    assign bus.dataOut   = r_result;
    assign bus.c_out     = r_c_out;
    assign bus.zero      = r_zero;
`ifdef ALU_OVERFLOW_EN
    assign bus.overflow  = r_ovf;
`endif
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed scoreboard bench for alu_iter (SLICE=8 and SLICE=32 instances)
module tb_alu_iter;
    import alu_pkg::*;
    typedef struct packed {
        logic [31:0] d;
        logic        c;
        logic        z;
        logic        v;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    alu_iter_if #(.WIDTH(32)) bus ();
    alu_iter_if #(.WIDTH(32)) bus1 ();
    alu_iter #(.WIDTH(32), .SLICE(8))  dut  (.clk(clk), .reset(rst_n), .bus(bus));
    alu_iter #(.WIDTH(32), .SLICE(32)) dut1 (.clk(clk), .reset(rst_n), .bus(bus1));
    exp_t q[$];
    int checks = 0;
    int errors = 0;
    function automatic exp_t model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [32:0] s;
        e = '0;
        if (op == ALU_ADD) begin
            s = {1'b0, a} + {1'b0, b};
            e.d = s[31:0];
            e.c = s[32];
            e.v = (a[31] == b[31]) && (s[31] != a[31]);
        end else if (op == ALU_SUB) begin
            s = {1'b0, a} + {1'b0, ~b} + 33'd1;
            e.d = s[31:0];
            e.c = s[32];
            e.v = (a[31] != b[31]) && (s[31] != a[31]);
        end else if (op == ALU_AND) e.d = a & b;
        else if (op == ALU_OR) e.d = a | b;
        else if (op == ALU_SLT) e.d = {31'b0, $signed(a) < $signed(b)};
        e.z = e.d == 32'b0;
        return e;
    endfunction
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask
    task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        int t = 0;
        q.push_back(model(op, a, b));
        while (!bus.in_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        bus.in_valid = 1'b1;
        bus.Signal   = op;
        bus.dataA    = a;
        bus.dataB    = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.Signal   = ALU_AND;
        bus.dataA    = $urandom;
        bus.dataB    = $urandom;
    endtask
    task automatic wait_result(input string tag);
        int n = 0;
        exp_t e;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (bus.out_valid) break;
        end
        check({tag, "_latency"}, n, 4);
        e = q.pop_front();
        check({tag, "_data"}, bus.dataOut, e.d);
        check({tag, "_cout"}, bus.c_out, e.c);
        check({tag, "_zero"}, bus.zero, e.z);
`ifdef ALU_OVERFLOW_EN
        check({tag, "_ovf"}, bus.overflow, e.v);
`endif
    endtask
    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_idle_ready"}, bus.in_ready, 1);
        check({tag, "_idle_valid"}, bus.out_valid, 0);
    endtask
    task automatic run(input string tag, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        send(op, a, b);
        wait_result(tag);
        handshake(tag);
    endtask
    initial begin
        int n;
        bus.in_valid = 1'b0; bus.Signal = '0; bus.dataA = '0; bus.dataB = '0; bus.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.Signal = '0; bus1.dataA = '0; bus1.dataB = '0; bus1.out_ready = 1'b0;
        #12;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_data", bus.dataOut, 0);
        check("rst_cout", bus.c_out, 0);
        check("rst_zero", bus.zero, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_in_ready", bus.in_ready, 1);
        run("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
        run("sub_neg", ALU_SUB, 32'd5, 32'd7);
        run("and", ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
        run("or", ALU_OR, 32'hF0F0_F0F0, 32'hFF00_FF00);
        run("slt_m1_1", ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        run("slt_ovf", ALU_SLT, 32'h7FFF_FFFF, 32'h8000_0000);
        run("slt_eq", ALU_SLT, 32'd3, 32'd3);
        run("sub_big", ALU_SUB, 32'h8000_0000, 32'h0000_0001);
        run("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'd1);
        run("bad_op", 6'b111111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        // backpressure: result held, competing request ignored until after handshake
        send(ALU_ADD, 32'h1234_5678, 32'h1111_1111);
        wait_result("bp");
        bus.in_valid = 1'b1; bus.Signal = ALU_ADD; bus.dataA = 32'd2; bus.dataB = 32'd2;
        q.push_back(model(ALU_ADD, 32'd2, 32'd2));
        repeat (3) begin
            @(posedge clk); #1;
            check("bp_hold_data", bus.dataOut, 32'h2345_6789);
            check("bp_hold_valid", bus.out_valid, 1);
            check("bp_hold_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("bp_release_in_ready", bus.in_ready, 1);
        check("bp_release_valid", bus.out_valid, 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("bp_accept", bus.in_ready, 0);
        wait_result("bp_new");
        handshake("bp_new");
        // reset during the second RUN cycle aborts the operation
        send(ALU_ADD, 32'h0000_AAAA, 32'h0000_5555);
        void'(q.pop_front());
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", bus.in_ready, 0);
        check("midrst_valid", bus.out_valid, 0);
        check("midrst_data", bus.dataOut, 0);
        check("midrst_cout", bus.c_out, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_rel_ready", bus.in_ready, 1);
        run("post_rst_add", ALU_ADD, 32'd2, 32'd3);
        // single-chunk instance: one RUN cycle
        bus1.in_valid = 1'b1; bus1.Signal = ALU_ADD; bus1.dataA = 32'h7FFF_FFFF; bus1.dataB = 32'd1;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (bus1.out_valid) break;
        end
        check("n1_latency", n, 1);
        check("n1_data", bus1.dataOut, 32'h8000_0000);
        check("n1_cout", bus1.c_out, 0);
`ifdef ALU_OVERFLOW_EN
        check("n1_ovf", bus1.overflow, 1);
`endif
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        bus1.out_ready = 1'b0;
        check("n1_idle", bus1.in_ready, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
